// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor: coin codes, FSM state types, audit width.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'b00,
    COIN_DIME    = 2'b01,
    COIN_QUARTER = 2'b10,
    COIN_SLUG    = 2'b11
  } coin_type_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_SETTLE,
    D_CLEAR
  } det_state_e;

  typedef enum logic [1:0] {
    E_IDLE,
    E_PULSE,
    E_GAP
  } emit_state_e;

  localparam int unsigned AUDIT_W = 16;

endpackage

// File: rtl/coin_acceptor_if.sv
// Chute-side inputs and vending-side outputs of the coin acceptor.
// master: the environment (chute sensor + vending FSM); slave: the acceptor.
interface coin_acceptor_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();
  import coin_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic               coin_sense;
  logic [1:0]         coin_type;
  logic               vend_busy;
  logic               nickel_in;
  logic               dime_in;
  logic               reject_pulse;
  logic [CW-1:0]      fifo_count;
  logic               overflow;
  logic [AUDIT_W-1:0] audit_credit;

  modport master (
    output coin_sense, coin_type, vend_busy,
    input  nickel_in, dime_in, reject_pulse, fifo_count, overflow, audit_credit
  );

  modport slave (
    input  coin_sense, coin_type, vend_busy,
    output nickel_in, dime_in, reject_pulse, fifo_count, overflow, audit_credit
  );

endinterface

// File: rtl/coin_fifo.sv
// Synchronous FIFO of accepted coins, 1-bit payload (0 = nickel, 1 = dime).
// Push on full and pop on empty are ignored.
module coin_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW = $clog2(FIFO_DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic [CW-1:0] count
);

  logic [FIFO_DEPTH-1:0] r_mem;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_do_push = push && (r_count != CW'(FIFO_DEPTH));
  assign w_do_pop  = pop && (r_count != '0);
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally (power-of-2 depth); count tracks occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: qualifies chute events, classifies coins, queues good ones and
// replays them as spaced single-cycle nickel_in/dime_in pulses.
// Optional macro COIN_AUDIT_EN enables the saturating audit_credit counter.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic            clock,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  det_state_e    r_det;
  emit_state_e   r_emit;
  logic [1:0]    r_type;
  logic [SW-1:0] r_settle_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic          r_reject;
  logic          r_overflow;
  logic          r_nickel;
  logic          r_dime;

  logic          w_stable;
  logic [SW-1:0] w_settle_inc;
  logic          w_qualify;
  logic [1:0]    w_qual_type;
  logic          w_good;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_din;
  logic          w_dout;
  logic [CW-1:0] w_count;

  assign w_stable     = bus.coin_sense && (bus.coin_type == r_type);
  assign w_settle_inc = r_settle_cnt + SW'(1);
  // With SETTLE_CYCLES == 1 the first sampled cycle already qualifies the coin.
  assign w_qualify    = ((r_det == D_IDLE) && bus.coin_sense && (SETTLE_CYCLES == 1)) ||
                        ((r_det == D_SETTLE) && w_stable &&
                         (w_settle_inc == SW'(SETTLE_CYCLES)));
  assign w_qual_type  = (r_det == D_IDLE) ? bus.coin_type : r_type;
  assign w_good       = (w_qual_type == COIN_NICKEL) || (w_qual_type == COIN_DIME);
  // Registered count only: a pop on the same edge does not free a slot.
  assign w_full       = (w_count == CW'(FIFO_DEPTH));
  assign w_push       = w_qualify && w_good && !w_full;
  assign w_din        = (w_qual_type == COIN_DIME);
  assign w_pop        = (r_emit == E_IDLE) && (w_count != '0) && !bus.vend_busy;

  coin_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count)
  );

  // Detector: debounce the chute, classify once per coin, drive reject/overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      // Start in D_CLEAR so a coin already in the chute is ignored until it leaves.
      r_det        <= D_CLEAR;
      r_type       <= '0;
      r_settle_cnt <= '0;
      r_reject     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_reject <= w_qualify && (!w_good || w_full);
      if (w_qualify && w_good && w_full) r_overflow <= 1'b1;
      unique case (r_det)
        D_IDLE: begin
          if (bus.coin_sense) begin
            r_type       <= bus.coin_type;
            r_settle_cnt <= SW'(1);
            r_det        <= w_qualify ? D_CLEAR : D_SETTLE;
          end
        end
        D_SETTLE: begin
          if (!w_stable)      r_det <= D_IDLE;
          else if (w_qualify) r_det <= D_CLEAR;
          else                r_settle_cnt <= w_settle_inc;
        end
        D_CLEAR: begin
          if (!bus.coin_sense) r_det <= D_IDLE;
        end
        default: r_det <= D_CLEAR;
      endcase
    end
  end

  // Emitter: pop one coin, pulse for one cycle, then hold off for GAP_CYCLES.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_emit    <= E_IDLE;
      r_nickel  <= 1'b0;
      r_dime    <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_nickel <= 1'b0;
      r_dime   <= 1'b0;
      unique case (r_emit)
        E_IDLE: begin
          if (w_pop) begin
            r_nickel <= !w_dout;
            r_dime   <= w_dout;
            r_emit   <= E_PULSE;
          end
        end
        E_PULSE: begin
          r_gap_cnt <= '0;
          r_emit    <= E_GAP;
        end
        E_GAP: begin
          if (r_gap_cnt == GW'(GAP_CYCLES - 1)) r_emit <= E_IDLE;
          else                                  r_gap_cnt <= r_gap_cnt + GW'(1);
        end
        default: r_emit <= E_IDLE;
      endcase
    end
  end

  assign bus.nickel_in    = r_nickel;
  assign bus.dime_in      = r_dime;
  assign bus.reject_pulse = r_reject;
  assign bus.overflow     = r_overflow;
  assign bus.fifo_count   = w_count;

`ifdef COIN_AUDIT_EN
  logic [AUDIT_W-1:0] r_audit;
  logic [AUDIT_W:0]   w_audit_sum;

  assign w_audit_sum = {1'b0, r_audit} + (r_dime   ? (AUDIT_W+1)'(2) :
                                          r_nickel ? (AUDIT_W+1)'(1) : '0);

  // Running credit in nickels, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) r_audit <= '0;
    else       r_audit <= w_audit_sum[AUDIT_W] ? '1 : w_audit_sum[AUDIT_W-1:0];
  end

  assign bus.audit_credit = r_audit;
`else
  assign bus.audit_credit = '0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus pushes expected pulses/rejects, a negedge
// monitor pops and compares. Honours COIN_AUDIT_EN for the audit expectations.
module tb_coin_acceptor;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 3;
  localparam int unsigned GAP    = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus ();

  coin_acceptor #(
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_pulse[$];   // 0 = nickel, 1 = dime, in credit order
  bit exp_rej[$];
  bit exp_ov = 1'b0;
  int exp_audit = 0;
  int occ = 0;        // model queue occupancy while vend_busy holds the emitter off

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int audit_exp();
`ifdef COIN_AUDIT_EN
    return exp_audit;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: a coin held >= SETTLE sampled cycles counts; good coins credit unless the
  // queue is full (only possible while the emitter is held off), others are returned.
  task automatic insert(input logic [1:0] t, input int h, input bit fill);
    if (h >= int'(SETTLE)) begin
      if (t < 2'd2) begin
        if (fill && occ >= int'(DEPTH)) begin
          exp_rej.push_back(1'b1);
          exp_ov = 1'b1;
        end else begin
          exp_pulse.push_back(t[0]);
          exp_audit += t[0] ? 2 : 1;
          if (fill) occ++;
        end
      end else begin
        exp_rej.push_back(1'b1);
      end
    end
    bus.coin_type  = t;
    bus.coin_sense = 1'b1;
    repeat (h) tick();
    bus.coin_sense = 1'b0;
    bus.coin_type  = 2'($urandom_range(0, 3));
    tick();
    tick();
  endtask

  task automatic drain();
    int k = 0;
    bus.vend_busy = 1'b0;
    while (exp_pulse.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    check("drain_pulses_left", exp_pulse.size(), 0);
    repeat (8) tick();
    check("drain_rejects_left", exp_rej.size(), 0);
    check("drain_fifo_count", int'(bus.fifo_count), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    exp_pulse.delete();
    exp_rej.delete();
    exp_ov    = 1'b0;
    exp_audit = 0;
    occ       = 0;
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  int since = -1;
  always @(negedge clock) begin
    if (bus.nickel_in || bus.dime_in) begin
      check("one_hot", int'(bus.nickel_in && bus.dime_in), 0);
      if (since >= 0) check("pulse_gap_ok", int'(since >= int'(GAP)), 1);
      check("pulse_expected", int'(exp_pulse.size() != 0), 1);
      if (exp_pulse.size() != 0) check("pulse_type", int'(bus.dime_in), int'(exp_pulse.pop_front()));
      since = 0;
    end else if (since >= 0) begin
      since++;
    end
    if (bus.reject_pulse) begin
      check("reject_expected", int'(exp_rej.size() != 0), 1);
      if (exp_rej.size() != 0) void'(exp_rej.pop_front());
    end
    if (reset) since = -1;
  end

  initial begin
    int k;
    int n;
    bus.coin_sense = 1'b0;
    bus.coin_type  = 2'b00;
    bus.vend_busy  = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_nickel", int'(bus.nickel_in), 0);
    check("rst_dime", int'(bus.dime_in), 0);
    check("rst_reject", int'(bus.reject_pulse), 0);
    check("rst_count", int'(bus.fifo_count), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_audit", int'(bus.audit_credit), 0);
    reset = 1'b0;
    tick();
    tick();

    // Nickel then dime, glitch, quarter.
    insert(2'b00, 3, 1'b0);
    insert(2'b01, 3, 1'b0);
    drain();
    insert(2'b00, 2, 1'b0);
    drain();
    insert(2'b10, 5, 1'b0);
    check("quarter_count", int'(bus.fifo_count), 0);
    drain();

    // Five nickels while busy: four queued, fifth returned with overflow.
    bus.vend_busy = 1'b1;
    occ = 0;
    repeat (5) insert(2'b00, 3, 1'b1);
    check("fill_count", int'(bus.fifo_count), 4);
    check("fill_overflow", int'(bus.overflow), 1);
    drain();

    // Randomised busy-fill rounds.
    for (int r = 0; r < 4; r++) begin
      bus.vend_busy = 1'b1;
      occ = 0;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) insert(2'($urandom_range(0, 3)), $urandom_range(1, 6), 1'b1);
      check("rnd_fill_count", int'(bus.fifo_count), occ);
      check("rnd_fill_overflow", int'(bus.overflow), int'(exp_ov));
      drain();
    end

    // Randomised free-running coins; arrivals are slower than the emitter drains.
    for (int i = 0; i < 25; i++) insert(2'($urandom_range(0, 3)), $urandom_range(1, 6), 1'b0);
    drain();
    check("rnd_overflow", int'(bus.overflow), int'(exp_ov));
    check("rnd_audit", int'(bus.audit_credit), audit_exp());

    // Reset mid-pulse with three queued and a dime sitting in the chute.
    bus.vend_busy = 1'b1;
    occ = 0;
    repeat (3) insert(2'b00, 3, 1'b1);
    bus.vend_busy = 1'b0;
    k = 0;
    while (!bus.nickel_in && k < 50) begin
      tick();
      k++;
    end
    check("pulse_before_reset", int'(bus.nickel_in), 1);
    bus.coin_type  = 2'b01;
    bus.coin_sense = 1'b1;
    reset = 1'b1;
    tick();
    exp_pulse.delete();
    exp_rej.delete();
    exp_ov    = 1'b0;
    exp_audit = 0;
    check("rst_mid_nickel", int'(bus.nickel_in), 0);
    check("rst_mid_dime", int'(bus.dime_in), 0);
    check("rst_mid_reject", int'(bus.reject_pulse), 0);
    check("rst_mid_count", int'(bus.fifo_count), 0);
    reset = 1'b0;
    repeat (6) tick();
    check("held_coin_count", int'(bus.fifo_count), 0);
    bus.coin_sense = 1'b0;
    tick();
    tick();
    drain();
    insert(2'b01, 3, 1'b0);
    drain();

    // Audit: two nickels and three dimes from a clean reset.
    do_reset();
    insert(2'b00, 3, 1'b0);
    insert(2'b01, 4, 1'b0);
    insert(2'b01, 3, 1'b0);
    insert(2'b00, 5, 1'b0);
    insert(2'b01, 3, 1'b0);
    drain();
`ifdef COIN_AUDIT_EN
    check("audit_total", int'(bus.audit_credit), 8);
`else
    check("audit_total", int'(bus.audit_credit), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
